// File: rtl/d5m_pkg.sv
// rtl/d5m_pkg.sv - shared types and constants for the D5M pattern generator
//
// Purpose : state and pattern-mode encodings plus pixel width constants used
//           by d5m_pattern_gen and d5m_pattern_pixel.
// Ports   : none (package)

package d5m_pkg;

    localparam int              PIX_W   = 12;
    localparam logic [PIX_W-1:0] PIX_MAX = 12'hFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SOF    = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        VBLANK = 3'd4
    } d5m_state_e;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_HRAMP = 2'd1,
        PAT_VRAMP = 2'd2,
        PAT_CHECK = 2'd3
    } pat_mode_e;

endpackage

// File: rtl/d5m_pattern_pixel.sv
// rtl/d5m_pattern_pixel.sv - combinational test-pattern pixel function
//
// Purpose : maps (mode, x, y, bar index) to one 12-bit Bayer pixel value.
//           The parent registers the result, so this block is purely
//           combinational.
// Ports   : i_mode      pattern select (bars / h-ramp / v-ramp / checker)
//           i_x, i_y    low 12 bits of the pixel coordinates
//           i_bar_idx   colour bar index 0..7 (already saturated)
//           o_pix       pixel value

module d5m_pattern_pixel
    import d5m_pkg::*;
(
    input  pat_mode_e              i_mode,
    input  logic [11:0]            i_x,
    input  logic [11:0]            i_y,
    input  logic [2:0]             i_bar_idx,
    output logic [PIX_W-1:0]       o_pix
);

    logic [2:0] w_bar_rgb;
    logic       w_site_on;

    // Leftmost bar is white (7 = R|G|B), rightmost is black.
    assign w_bar_rgb = 3'd7 - i_bar_idx;

    // Pick the colour bit for the Bayer site at (x, y):
    // G where x[0]==y[0], R on even rows, B on odd rows.
    always_comb begin
        w_site_on = 1'b0;
        if (i_x[0] == i_y[0]) begin
            w_site_on = w_bar_rgb[1];
        end else if (!i_y[0]) begin
            w_site_on = w_bar_rgb[2];
        end else begin
            w_site_on = w_bar_rgb[0];
        end
    end

    always_comb begin
        o_pix = '0;
        case (i_mode)
            PAT_BARS:  o_pix = w_site_on ? PIX_MAX : '0;
            PAT_HRAMP: o_pix = i_x;
            PAT_VRAMP: o_pix = i_y;
            PAT_CHECK: o_pix = (i_x[4] ^ i_y[4]) ? PIX_MAX : '0;
            default:   o_pix = '0;
        endcase
    end

endmodule

// File: rtl/d5m_pattern_gen.sv
// rtl/d5m_pattern_gen.sv - D5M sensor output emulator (FVAL/LVAL/12-bit Bayer)
//
// Purpose : streams synthetic frames with D5M-style framing so the capture
//           path can be exercised without a camera attached.
// Ports   : iCLK         pixel clock, rising edge
//           iRST_N       asynchronous active-low reset
//           iSTART       level, begins streaming when sampled in IDLE
//           iSTOP        level, halts the stream after the current frame
//           iMODE        0 bars, 1 h-ramp, 2 v-ramp, 3 checkerboard
//           oDATA        pixel value, 0 while oLVAL is low
//           oLVAL        line valid
//           oFVAL        frame valid
//           oFrame_Cont  completed-frame counter (wraps)
//           oBUSY        high whenever the FSM is not IDLE

module d5m_pattern_gen
    import d5m_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 64,
    parameter int FV2LV    = 4,
    parameter int V_BLANK  = 2000,
    parameter int BAR_W    = 160
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    input  logic              iSTOP,
    input  logic [1:0]        iMODE,
    output logic [PIX_W-1:0]  oDATA,
    output logic              oLVAL,
    output logic              oFVAL,
    output logic [31:0]       oFrame_Cont,
    output logic              oBUSY
);

    // All counters are 16 bits wide; refuse parameter sets that do not fit
    // or that break the framing rules.
    if (H_ACTIVE < 2 || H_ACTIVE > 65535 || (H_ACTIVE % 2) != 0 ||
        V_ACTIVE < 2 || V_ACTIVE > 65535 || (V_ACTIVE % 2) != 0 ||
        H_BLANK  < 1 || H_BLANK  > 65535 ||
        FV2LV    < 1 || FV2LV    > 65535 ||
        V_BLANK  < 1 || V_BLANK  > 65535 ||
        BAR_W    < 1 || BAR_W    > 65535) begin : g_bad_params
        $error("d5m_pattern_gen: parameter out of range for 16-bit counters");
    end

    localparam logic [15:0] C_HA_M1  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] C_VA_M1  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] C_HB_M1  = 16'(H_BLANK - 1);
    localparam logic [15:0] C_F2L_M1 = 16'(FV2LV - 1);
    localparam logic [15:0] C_VB_M1  = 16'(V_BLANK - 1);
    localparam logic [15:0] C_BW_M1  = 16'(BAR_W - 1);

    d5m_state_e        r_state,   w_state_nxt;
    pat_mode_e         r_mode,    w_mode_nxt;
    logic [15:0]       r_x,       w_x_nxt;
    logic [15:0]       r_y,       w_y_nxt;
    logic [15:0]       r_cnt,     w_cnt_nxt;
    logic [15:0]       r_bar_cnt, w_bar_cnt_nxt;
    logic [2:0]        r_bar_idx, w_bar_idx_nxt;
    logic              r_stop,    w_stop_nxt;
    logic              w_frame_done;
    logic [PIX_W-1:0]  w_pix;

    logic [PIX_W-1:0]  r_data;
    logic              r_lval;
    logic              r_fval;
    logic              r_busy;
    logic [31:0]       r_frame_cont;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= IDLE;
            r_mode    <= PAT_BARS;
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_stop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bar_cnt <= w_bar_cnt_nxt;
            r_bar_idx <= w_bar_idx_nxt;
            r_stop    <= w_stop_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_cnt_nxt     = r_cnt;
        w_bar_cnt_nxt = r_bar_cnt;
        w_bar_idx_nxt = r_bar_idx;
        w_stop_nxt    = r_stop;
        w_frame_done  = 1'b0;

        case (r_state)
            IDLE: begin
                w_stop_nxt = 1'b0;
                if (iSTART && !iSTOP) begin
                    w_state_nxt = SOF;
                    w_mode_nxt  = pat_mode_e'(iMODE);
                    w_cnt_nxt   = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end
            end

            SOF: begin
                w_stop_nxt = r_stop | iSTOP;
                if (r_cnt == C_F2L_M1) begin
                    w_state_nxt   = ACTIVE;
                    w_x_nxt       = '0;
                    w_bar_cnt_nxt = C_BW_M1;
                    w_bar_idx_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ACTIVE: begin
                w_stop_nxt = r_stop | iSTOP;
                if (r_x == C_HA_M1) begin
                    w_state_nxt = HBLANK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_x_nxt = r_x + 16'd1;
                    // Bar index advances every BAR_W pixels and sticks at
                    // the last (black) bar.
                    if (r_bar_cnt == 16'd0) begin
                        w_bar_cnt_nxt = C_BW_M1;
                        if (r_bar_idx != 3'd7) begin
                            w_bar_idx_nxt = r_bar_idx + 3'd1;
                        end
                    end else begin
                        w_bar_cnt_nxt = r_bar_cnt - 16'd1;
                    end
                end
            end

            HBLANK: begin
                w_stop_nxt = r_stop | iSTOP;
                if (r_cnt == C_HB_M1) begin
                    if (r_y < C_VA_M1) begin
                        w_state_nxt   = ACTIVE;
                        w_y_nxt       = r_y + 16'd1;
                        w_x_nxt       = '0;
                        w_bar_cnt_nxt = C_BW_M1;
                        w_bar_idx_nxt = '0;
                    end else begin
                        w_state_nxt  = VBLANK;
                        w_cnt_nxt    = '0;
                        w_frame_done = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            VBLANK: begin
                w_stop_nxt = r_stop | iSTOP;
                if (r_cnt == C_VB_M1) begin
                    if (w_stop_nxt) begin
                        w_state_nxt = IDLE;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = SOF;
                        w_mode_nxt  = pat_mode_e'(iMODE);
                        w_cnt_nxt   = '0;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_stop_nxt  = 1'b0;
            end
        endcase
    end

    // The pixel is computed from next-cycle coordinates so that the
    // registered output lines up with the registered LVAL.
    d5m_pattern_pixel u_pixel (
        .i_mode    (w_mode_nxt),
        .i_x       (w_x_nxt[11:0]),
        .i_y       (w_y_nxt[11:0]),
        .i_bar_idx (w_bar_idx_nxt),
        .o_pix     (w_pix)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_data       <= '0;
            r_lval       <= 1'b0;
            r_fval       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_cont <= '0;
        end else begin
            r_fval <= (w_state_nxt == SOF) || (w_state_nxt == ACTIVE) ||
                      (w_state_nxt == HBLANK);
            r_lval <= (w_state_nxt == ACTIVE);
            r_data <= (w_state_nxt == ACTIVE) ? w_pix : '0;
            r_busy <= (w_state_nxt != IDLE);
            if (w_frame_done) begin
                r_frame_cont <= r_frame_cont + 32'd1;
            end
        end
    end

    assign oDATA       = r_data;
    assign oLVAL       = r_lval;
    assign oFVAL       = r_fval;
    assign oBUSY       = r_busy;
    assign oFrame_Cont = r_frame_cont;

endmodule

// File: tb/tb_d5m_pattern_gen.sv
// tb/tb_d5m_pattern_gen.sv - self-checking bench for d5m_pattern_gen

module tb_d5m_pattern_gen;

    localparam int HA  = 8;
    localparam int VA  = 4;
    localparam int HB  = 3;
    localparam int F2L = 2;
    localparam int VB  = 5;
    localparam int BW  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [11:0] data;
    logic        lval;
    logic        fval;
    logic [31:0] cont;
    logic        busy;

    int n_cmp    = 0;
    int n_bad    = 0;
    int frame_no = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    d5m_pattern_gen #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .FV2LV    (F2L),
        .V_BLANK  (VB),
        .BAR_W    (BW)
    ) u_dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iSTART      (start),
        .iSTOP       (stop),
        .iMODE       (mode),
        .oDATA       (data),
        .oLVAL       (lval),
        .oFVAL       (fval),
        .oFrame_Cont (cont),
        .oBUSY       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s frame=%0d cyc=%0d got=%0h exp=%0h", tag, frame_no, cyc, got, exp);
        end
    endtask

    // Reference pixel straight from the pattern rules, using division and
    // modulo on integer coordinates.
    function automatic logic [11:0] ref_pix(input int m, input int x, input int y);
        int idx;
        int rgb;
        int on;
        case (m)
            0: begin
                idx = x / BW;
                if (idx > 7) idx = 7;
                rgb = 7 - idx;
                if ((x % 2) == (y % 2))  on = (rgb / 2) % 2;
                else if ((y % 2) == 0)   on = rgb / 4;
                else                     on = rgb % 2;
                return (on != 0) ? 12'hFFF : 12'h000;
            end
            1:       return 12'(x % 4096);
            2:       return 12'(y % 4096);
            default: return ((((x / 16) + (y / 16)) % 2) == 1) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic check_idle(input int exp_cont);
        chk("idle_fval", fval, 0);
        chk("idle_lval", lval, 0);
        chk("idle_data", data, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cont", cont, exp_cont);
    endtask

    // Checks the current cycle, then drives inputs for the next edge.
    task automatic one_cycle(input logic exp_fv, input logic exp_lv, input logic [11:0] exp_d,
                             input int exp_cont, input int stop_at, input logic last,
                             input int nxt_mode);
        chk("fval", fval, exp_fv);
        chk("lval", lval, exp_lv);
        chk("data", data, exp_d);
        chk("busy", busy, 1);
        chk("cont", cont, exp_cont);
        mode = last ? 2'(nxt_mode) : 2'($urandom_range(0, 3));
        stop = (cyc == stop_at);
        @(negedge clk);
        cyc++;
    endtask

    // Entered on the first SOF cycle; returns on the cycle after V_BLANK.
    task automatic run_frame(input int m, input int stop_at, input int nxt_mode, input int cont_before);
        cyc = 0;
        for (int i = 0; i < F2L; i++)
            one_cycle(1'b1, 1'b0, 12'h0, cont_before, stop_at, 1'b0, nxt_mode);
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++)
                one_cycle(1'b1, 1'b1, ref_pix(m, x, y), cont_before, stop_at, 1'b0, nxt_mode);
            for (int h = 0; h < HB; h++)
                one_cycle(1'b1, 1'b0, 12'h0, cont_before, stop_at, 1'b0, nxt_mode);
        end
        for (int v = 0; v < VB; v++)
            one_cycle(1'b0, 1'b0, 12'h0, cont_before + 1, stop_at, (v == VB - 1), nxt_mode);
        frame_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m;
        int nm;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check_idle(0);

        // Start is ignored while reset is held.
        start = 1'b1;
        @(negedge clk);
        chk("rst_hold_fval", fval, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0);

        // Free-running frames; iMODE is randomised inside each frame and
        // only the value present at the SOF edge may take effect.
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame(1, -1, 0, 0);
        run_frame(0, -1, 2, 1);
        run_frame(2, -1, 3, 2);
        nm = int'($urandom_range(0, 3));
        run_frame(3, F2L + 2 * (HA + HB) + int'($urandom_range(0, HA - 1)), nm, 3);
        check_idle(4);
        repeat (10) begin
            @(negedge clk);
            chk("stay_idle", busy, 0);
        end

        // START with STOP in IDLE: nothing happens.
        start = 1'b1;
        stop  = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("ss_fval", fval, 0);
            chk("ss_busy", busy, 0);
        end

        // START held high through the frame; STOP raised during V_BLANK.
        stop = 1'b0;
        mode = 2'd3;
        @(negedge clk);
        run_frame(3, F2L + VA * (HA + HB) + int'($urandom_range(0, VB - 2)), 0, 4);
        check_idle(5);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of an active line.
        m     = int'($urandom_range(0, 3));
        mode  = 2'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (F2L + 3) @(negedge clk);
        chk("pre_rst_lval", lval, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle(0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_fval", fval, 0);
            chk("post_rst_busy", busy, 0);
        end

        // Fresh start after reset, stopped early in the frame.
        m     = int'($urandom_range(0, 3));
        mode  = 2'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_frame(m, 5, 0, 0);
        check_idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
